prm_edge_scan: RTL

PRM_EDGE_SCAN -- requirements
Module: prm_edge_scan

---
 rtl/prm_edge_scan.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prm_edge_scan.sv
// Edge-range scanner: walks chk_idx over [idx_first, idx_last], packs the returned
// edge mask bits into WORD_W-bit words. Define PRM_SCAN_BLKCNT_EN to build the blocked-edge counter.
module prm_edge_scan #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [14:0]       idx_first,
    input  logic [14:0]       idx_last,
    output logic [14:0]       chk_idx,
    input  logic              chk_mask,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       blk_cnt
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUSH, S_FIN} state_t;

    state_t              r_state,     w_state;
    logic [14:0]         r_chk_idx,   w_chk_idx;
    logic [14:0]         r_last_idx,  w_last_idx;
    logic [WORD_W-1:0]   r_pack,      w_pack;
    logic [CNT_W-1:0]    r_bit_cnt,   w_bit_cnt;
    logic [WORD_W-1:0]   r_out_data,  w_out_data;
    logic                r_out_valid, w_out_valid;
    logic                r_out_last,  w_out_last;
    logic                r_busy,      w_busy;
    logic                r_done,      w_done;

    logic [15:0]         w_idx_inc;
    logic                w_at_last;
    logic                w_word_full;
    logic [WORD_W-1:0]   w_sample_word;

    // 16-bit increment/compare keeps idx_last=0x7FFF from wrapping the index to 0
    assign w_idx_inc     = {1'b0, r_chk_idx} + 16'd1;
    assign w_at_last     = (w_idx_inc > {1'b0, r_last_idx});
    assign w_word_full   = (r_bit_cnt == CNT_W'(WORD_W - 1));
    assign w_sample_word = r_pack | (WORD_W'(chk_mask) << r_bit_cnt);

    always_comb begin
        w_state     = r_state;
        w_chk_idx   = r_chk_idx;
        w_last_idx  = r_last_idx;
        w_pack      = r_pack;
        w_bit_cnt   = r_bit_cnt;
        w_out_data  = r_out_data;
        w_out_valid = r_out_valid;
        w_out_last  = r_out_last;
        w_busy      = r_busy;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy = 1'b1;
                    if (idx_first <= idx_last) begin
                        w_chk_idx  = idx_first;
                        w_last_idx = idx_last;
                        w_pack     = '0;
                        w_bit_cnt  = '0;
                        w_state    = S_SCAN;
                    end else begin
                        w_state = S_FIN;
                    end
                end
            end
            S_SCAN: begin
                w_pack    = w_sample_word;
                w_bit_cnt = r_bit_cnt + CNT_W'(1);
                if (!w_at_last) begin
                    w_chk_idx = w_idx_inc[14:0];
                end
                if (w_at_last || w_word_full) begin
                    w_out_data  = w_sample_word;
                    w_out_valid = 1'b1;
                    w_out_last  = w_at_last;
                    w_state     = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    w_out_valid = 1'b0;
                    w_out_last  = 1'b0;
                    w_pack      = '0;
                    w_bit_cnt   = '0;
                    w_state     = r_out_last ? S_FIN : S_SCAN;
                end
            end
            S_FIN: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_chk_idx   <= '0;
            r_last_idx  <= '0;
            r_pack      <= '0;
            r_bit_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_chk_idx   <= w_chk_idx;
            r_last_idx  <= w_last_idx;
            r_pack      <= w_pack;
            r_bit_cnt   <= w_bit_cnt;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

`ifdef PRM_SCAN_BLKCNT_EN
    logic [15:0] r_blk_cnt;

    // Cleared on any accepted start, including an empty range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_blk_cnt <= '0;
        end else if (r_state == S_SCAN && chk_mask) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`else
    assign blk_cnt = '0;
`endif

    assign chk_idx   = r_chk_idx;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
